// File: rtl/dmac_pkg.sv
// Shared TCDM request record used by the DMA-side request buffer.
// The record is packed {add, wen, be, data}, with add in the MSBs.
package dmac_pkg;

  localparam int unsigned TCDM_ADDR_WIDTH = 32;
  localparam int unsigned TCDM_DATA_WIDTH = 32;
  localparam int unsigned TCDM_BE_WIDTH   = TCDM_DATA_WIDTH / 8;

  typedef struct packed {
    logic [TCDM_ADDR_WIDTH-1:0] add;
    logic                       wen;
    logic [TCDM_BE_WIDTH-1:0]   be;
    logic [TCDM_DATA_WIDTH-1:0] data;
  } tcdm_req_t;

  localparam int unsigned TCDM_REQ_WIDTH = $bits(tcdm_req_t);

  // Flat record width for non-default address/byte-enable/data widths.
  function automatic int unsigned req_width(input int unsigned aw, input int unsigned bw,
                                            input int unsigned dw);
    return aw + 1 + bw + dw;
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// Small synchronous FIFO with an asynchronous-read head; FALL_THROUGH=1 lets
// an empty FIFO forward its input combinationally. DEPTH must be a power of 2.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  typedef logic [ADDR_DEPTH-1:0] ptr_t;
  localparam ptr_t LAST = ptr_t'(DEPTH - 1);

  ptr_t                  rd_ptr_reg, rd_ptr_next, wr_ptr_reg, wr_ptr_next;
  logic [ADDR_DEPTH:0]   cnt_reg, cnt_next;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  is_empty, push_ok, pop_ok, pass_through;

  assign is_empty     = (cnt_reg == '0);
  assign full_o       = (cnt_reg == (ADDR_DEPTH+1)'(DEPTH));
  assign empty_o      = is_empty & ~(FALL_THROUGH & push_i);
  assign data_o       = (FALL_THROUGH && is_empty) ? data_i : mem[rd_ptr_reg];
  assign push_ok      = push_i & ~full_o;
  assign pop_ok       = pop_i & ~empty_o;
  // A word forwarded straight through an empty FIFO never touches storage.
  assign pass_through = FALL_THROUGH & is_empty & push_ok & pop_ok;

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    cnt_next    = cnt_reg;
    if (push_ok && !pass_through)
      wr_ptr_next = (wr_ptr_reg == LAST) ? '0 : wr_ptr_reg + 1'b1;
    if (pop_ok && !pass_through)
      rd_ptr_next = (rd_ptr_reg == LAST) ? '0 : rd_ptr_reg + 1'b1;
    if (push_ok && !pop_ok)
      cnt_next = cnt_reg + 1'b1;
    else if (pop_ok && !push_ok)
      cnt_next = cnt_reg - 1'b1;
    if (flush_i) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      cnt_next    = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      cnt_reg    <= cnt_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok && !pass_through)
      mem[wr_ptr_reg] <= data_i;
  end

endmodule

// File: rtl/dmac_tcdm_buffer.sv
// Decouples one DMA TCDM port from the interconnect: registered request FIFO
// plus an outstanding-read limiter; read responses pass straight through.
module dmac_tcdm_buffer
  import dmac_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
  parameter int unsigned DEPTH           = 2,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_req_i,
  input  logic [ADDR_WIDTH-1:0] in_add_i,
  input  logic                  in_wen_i,
  input  logic [BE_WIDTH-1:0]   in_be_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  in_gnt_o,
  output logic                  in_r_valid_o,
  output logic [DATA_WIDTH-1:0] in_r_data_o,
  output logic                  out_req_o,
  output logic [ADDR_WIDTH-1:0] out_add_o,
  output logic                  out_wen_o,
  output logic [BE_WIDTH-1:0]   out_be_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  input  logic                  out_gnt_i,
  input  logic                  out_r_valid_i,
  input  logic [DATA_WIDTH-1:0] out_r_data_i,
  output logic                  busy_o
);

  localparam int unsigned REQ_W = req_width(ADDR_WIDTH, BE_WIDTH, DATA_WIDTH);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [REQ_W-1:0] push_rec, head_rec;
  logic             fifo_full, fifo_empty, push, pop, read_pop, rsp_dec, at_limit;
  logic [CNT_W-1:0] outcnt_reg, outcnt_next;

  assign push_rec = {in_add_i, in_wen_i, in_be_i, in_data_i};
  assign {out_add_o, out_wen_o, out_be_o, out_data_o} = head_rec;

  // Grant depends only on registered occupancy, never on this cycle's pop.
  assign in_gnt_o = ~fifo_full;
  assign push     = in_req_i & in_gnt_o;

  assign at_limit  = out_wen_o & (outcnt_reg == CNT_W'(MAX_OUTSTANDING));
  assign out_req_o = ~fifo_empty & ~at_limit;
  assign pop       = out_req_o & out_gnt_i;
  assign read_pop  = pop & out_wen_o;

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   (REQ_W),
    .DEPTH        (DEPTH)
  ) i_req_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .data_i  (push_rec),
    .push_i  (push),
    .data_o  (head_rec),
    .pop_i   (pop)
  );

  // A response with nothing outstanding is ignored so the count cannot wrap.
  assign rsp_dec = out_r_valid_i & (outcnt_reg != '0);

  always_comb begin
    outcnt_next = outcnt_reg;
    if (read_pop && !rsp_dec)
      outcnt_next = outcnt_reg + 1'b1;
    else if (!read_pop && rsp_dec)
      outcnt_next = outcnt_reg - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni)
      outcnt_reg <= '0;
    else
      outcnt_reg <= outcnt_next;
  end

  assign in_r_valid_o = out_r_valid_i;
  assign in_r_data_o  = out_r_data_i;
  assign busy_o       = ~fifo_empty | (outcnt_reg != '0);

  a_no_spurious_rsp : assert property (@(posedge clk_i) disable iff (!rst_ni)
    out_r_valid_i |-> (outcnt_reg != '0));

endmodule

// File: doc/dmac_tcdm_buffer.md
DMAC_TCDM_BUFFER -- requirements
Module: dmac_tcdm_buffer

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, TCDM address width.
REQ-002 Parameter DATA_WIDTH, default 32, TCDM data width.
REQ-003 Parameter BE_WIDTH, default DATA_WIDTH/8, byte-enable width.
REQ-004 Parameter DEPTH, default 2, request FIFO entries (power of 2, >=2).
REQ-005 Parameter MAX_OUTSTANDING, default 8, maximum reads in flight downstream.
REQ-006 Clock and reset: one clock; reset is synchronous and active-low. Ports are clk_i and rst_ni.
REQ-007 clk_i  input  1  clock, all state on rising edge.
REQ-008 rst_ni  input  1  synchronous active-low reset.
REQ-009 in_req_i / in_add_i / in_wen_i / in_be_i / in_data_i  input  1/ADDR_WIDTH/1/BE_WIDTH/DATA_WIDTH  request from one DMA TCDM initiator port (wen=1 read, wen=0 write).
REQ-010 in_gnt_o  output  1  request accepted this cycle.
REQ-011 in_r_valid_o / in_r_data_o  output  1/DATA_WIDTH  read response to the DMA.
REQ-012 out_req_o / out_add_o / out_wen_o / out_be_o / out_data_o  output  1/ADDR_WIDTH/1/BE_WIDTH/DATA_WIDTH  request to the TCDM interconnect.
REQ-013 out_gnt_i  input  1  interconnect grant.
REQ-014 out_r_valid_i / out_r_data_i  input  1/DATA_WIDTH  interconnect read response.
REQ-015 busy_o  output  1  FIFO non-empty or reads outstanding.

Function
REQ-016 Upstream handshake (push) SHALL occur when in_req_i & in_gnt_o; in_gnt_o = !full, from registered state only, independent of in_req_i and out_gnt_i.
REQ-017 Push while full SHALL NOT occur, even if a pop happens in the same cycle.
REQ-018 Downstream request SHALL be out_req_o = !empty & !(head is read & outcnt == MAX_OUTSTANDING); out_* fields SHALL be the FIFO head.
REQ-019 Pop SHALL occur on out_req_o & out_gnt_i; FIFO order is strict in-order.
REQ-020 No bypass: a request pushed in cycle N SHALL appear on out_req_o no earlier than cycle N+1.
REQ-021 out_* payload SHALL stay stable while out_req_o=1 and out_gnt_i=0.
REQ-022 Simultaneous push and pop (not full) SHALL leave occupancy unchanged; pointers wrap modulo DEPTH.
REQ-023 Outstanding counter outcnt (width clog2(MAX_OUTSTANDING+1)) SHALL +1 on pop of a read, -1 on out_r_valid_i, unchanged when both occur.
REQ-024 Writes SHALL NOT increment outcnt; out_r_valid_i for writes is not expected.
REQ-025 in_r_valid_o = out_r_valid_i and in_r_data_o = out_r_data_i, combinational, zero added latency.
REQ-026 out_r_valid_i when outcnt==0 is a protocol error: outcnt SHALL saturate at 0 (assertion fires in simulation).
REQ-027 busy_o = !empty | (outcnt != 0), combinational from registers.

Reset
REQ-028 On rst_ni=0 at a clock edge: pointers, occupancy and outcnt SHALL clear to 0; FIFO data need not reset.
REQ-029 Reset values: in_gnt_o=1, out_req_o=0, busy_o=0, in_r_valid_o follows out_r_valid_i.
REQ-030 Reset mid-operation SHALL discard queued requests and outstanding count; responses after reset are not tracked.

Structure
REQ-031 Request record typedef (add, wen, be, data) and its width constant SHALL live in dmac_pkg, parameterised by ADDR/DATA widths.
REQ-032 FIFO storage SHALL be a single sub-module instance of common_cells fifo_v3 (FALL_THROUGH=0); counter and gating logic live in the top.

Verification
REQ-033 Single write add=0x100 data=0xDEADBEEF, out_gnt_i=1 -> out_req_o high 1 cycle after push with same payload; busy_o low 2 cycles after push.
REQ-034 Burst of 4 reads, out_gnt_i=0 -> in_gnt_o drops after 2 pushes (DEPTH=2); releasing gnt drains in order 0x0,0x4,0x8,0xC.
REQ-035 9 reads granted, no responses, MAX_OUTSTANDING=8 -> 9th held, out_req_o=0 at outcnt=8; one out_r_valid_i -> 9th issued next cycle.
REQ-036 Pop of read and out_r_valid_i in same cycle at outcnt=3 -> outcnt stays 3; r_data 0xA5A5A5A5 appears on in_r_data_o same cycle.
REQ-037 Reset asserted with 2 queued and 5 outstanding -> next cycle out_req_o=0, in_gnt_o=1, busy_o=0.
REQ-038 Random push/gnt/response stress 10k cycles -> in-order scoreboard match, payload stable under stall, no overflow.
